// File: rtl/power_seq_ctrl.sv
// rtl/power_seq_ctrl.sv - two-rail power sequencer driven by ASCII command pairs
// Rail N must report good before rail P is enabled; P is dropped before N on the way down.
module power_seq_ctrl #(
  parameter int SEQ_DLY = 500000,
  parameter int PG_TO   = 2500000,
  parameter int BYTE_TO = 5000000,
  parameter int CNT_W   = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] po_data,
  input  logic       rx_down,
  input  logic       pg_n,
  input  logic       pg_p,
  output logic       en_n,
  output logic       en_p,
  output logic       busy,
  output logic       fault,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_ack
);

  localparam logic [CNT_W-1:0] SEQ_LAST  = CNT_W'(SEQ_DLY - 1);
  localparam logic [CNT_W-1:0] PG_LAST   = CNT_W'(PG_TO - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BYTE_TO - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [15:0] CMD_N1 = 16'h4E31;
  localparam logic [15:0] CMD_N0 = 16'h4E30;
  localparam logic [15:0] CMD_P1 = 16'h5031;
  localparam logic [15:0] CMD_P0 = 16'h5030;

  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;
  localparam logic [7:0] RSP_B = 8'h42;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [2:0] {
    ST_STEADY,
    ST_N_PG,
    ST_GAP_UP,
    ST_P_PG,
    ST_GAP_DN,
    ST_FAULT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             tgt_n;
  logic             tgt_p;

  logic [1:0] pg_n_sync;
  logic [1:0] pg_p_sync;
  logic       pg_n_s;
  logic       pg_p_s;

  logic             have_first;
  logic [7:0]       first_byte;
  logic [CNT_W-1:0] byte_timer;
  logic             pair_valid;
  logic [15:0]      pair;
  logic             byte_exp;
  logic             is_eol;

  logic pair_known;
  logic next_tn;
  logic next_tp;
  logic fault_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_n_sync <= 2'b00;
      pg_p_sync <= 2'b00;
    end else begin
      pg_n_sync <= {pg_n_sync[0], pg_n};
      pg_p_sync <= {pg_p_sync[0], pg_p};
    end
  end

  assign pg_n_s = pg_n_sync[1];
  assign pg_p_s = pg_p_sync[1];

  assign byte_exp = have_first && (byte_timer == BYTE_LAST);
  assign is_eol   = (po_data == CH_CR) || (po_data == CH_LF);

  // An expiring first byte is dropped before a coincident byte is considered,
  // so that byte starts a fresh pair instead of completing a stale one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_first <= 1'b0;
      first_byte <= 8'h00;
      byte_timer <= '0;
      pair_valid <= 1'b0;
      pair       <= 16'h0000;
    end else begin
      pair_valid <= 1'b0;
      if (have_first) begin
        byte_timer <= byte_timer + CNT_ONE;
      end
      if (have_first && !byte_exp && rx_down) begin
        pair       <= {first_byte, po_data};
        pair_valid <= 1'b1;
        have_first <= 1'b0;
      end else if ((!have_first || byte_exp) && rx_down && !is_eol) begin
        first_byte <= po_data;
        byte_timer <= '0;
        have_first <= 1'b1;
      end else if (byte_exp) begin
        have_first <= 1'b0;
      end
    end
  end

  always_comb begin
    pair_known = 1'b1;
    next_tn    = tgt_n;
    next_tp    = tgt_p;
    if (pair == CMD_N1) begin
      next_tn = 1'b1;
    end else if (pair == CMD_N0) begin
      next_tn = 1'b0;
      next_tp = 1'b0;
    end else if (pair == CMD_P1) begin
      next_tn = 1'b1;
      next_tp = 1'b1;
    end else if (pair == CMD_P0) begin
      next_tp = 1'b0;
    end else begin
      pair_known = 1'b0;
    end
  end

  always_comb begin
    fault_hit = 1'b0;
    case (state)
      ST_STEADY: fault_hit = (en_n && !pg_n_s) || (en_p && !pg_p_s);
      ST_N_PG:   fault_hit = !pg_n_s && (cnt == PG_LAST);
      ST_P_PG:   fault_hit = !pg_p_s && (cnt == PG_LAST);
      default:   fault_hit = 1'b0;
    endcase
  end

  assign busy = (state != ST_STEADY) || (tgt_n != en_n) || (tgt_p != en_p);

  // Command handling sits ahead of the FSM so a fault entry in the same
  // cycle overrides any target or fault-flag update from a pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_STEADY;
      cnt     <= '0;
      en_n    <= 1'b0;
      en_p    <= 1'b0;
      tgt_n   <= 1'b0;
      tgt_p   <= 1'b0;
      fault   <= 1'b0;
      tx_req  <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      if (tx_req && tx_ack) begin
        tx_req <= 1'b0;
      end
      if (pair_valid && !tx_req) begin
        tx_req <= 1'b1;
        if (fault) begin
          if (pair == CMD_N0) begin
            fault   <= 1'b0;
            tx_data <= RSP_K;
          end else begin
            tx_data <= RSP_E;
          end
        end else if (!pair_known) begin
          tx_data <= RSP_E;
        end else if (busy) begin
          tx_data <= RSP_B;
        end else begin
          tx_data <= RSP_K;
          tgt_n   <= next_tn;
          tgt_p   <= next_tp;
        end
      end

      cnt <= cnt + CNT_ONE;
      if (fault_hit) begin
        state <= ST_FAULT;
        cnt   <= '0;
        en_n  <= 1'b0;
        en_p  <= 1'b0;
        tgt_n <= 1'b0;
        tgt_p <= 1'b0;
        fault <= 1'b1;
      end else begin
        case (state)
          ST_STEADY: begin
            if (en_p && !tgt_p) begin
              en_p  <= 1'b0;
              state <= ST_GAP_DN;
              cnt   <= '0;
            end else if (en_n && !tgt_n && !en_p) begin
              en_n <= 1'b0;
            end else if (!en_n && tgt_n) begin
              en_n  <= 1'b1;
              state <= ST_N_PG;
              cnt   <= '0;
            end else if (en_n && !en_p && tgt_p) begin
              state <= ST_GAP_UP;
              cnt   <= '0;
            end
          end
          ST_N_PG: begin
            if (pg_n_s) begin
              state <= ST_STEADY;
              cnt   <= '0;
            end
          end
          ST_GAP_UP: begin
            if (cnt == SEQ_LAST) begin
              en_p  <= 1'b1;
              state <= ST_P_PG;
              cnt   <= '0;
            end
          end
          ST_P_PG: begin
            if (pg_p_s) begin
              state <= ST_STEADY;
              cnt   <= '0;
            end
          end
          ST_GAP_DN: begin
            if (cnt == SEQ_LAST) begin
              state <= ST_STEADY;
              cnt   <= '0;
            end
          end
          ST_FAULT: begin
            state <= ST_STEADY;
            cnt   <= '0;
          end
          default: begin
            state <= ST_STEADY;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
